// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned SEG_W  = 7;

  typedef logic [1:0] digit_idx_t;

  localparam logic [AN_W-1:0] AN_OFF = 4'b1111;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 never is.
  function automatic logic lz_blank(input logic [VAL_W-1:0] val, input digit_idx_t idx);
    logic r;
    unique case (idx)
      2'd3:    r = (val[15:12] == 4'h0);
      2'd2:    r = (val[15:8]  == 8'h00);
      2'd1:    r = (val[15:4]  == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: value/enables/blink in, anodes/segments/frame pulse out.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [VAL_W-1:0] value;
  logic [AN_W-1:0]  dig_en;
  logic             blink;
  logic [AN_W-1:0]  an;
  logic [SEG_W-1:0] seg;
  logic             frame_tick;

  modport master (output value, dig_en, blink, input an, seg, frame_tick);
  modport slave  (input value, dig_en, blink, output an, seg, frame_tick);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg_c
);
  assign o_seg_c = SEG_TABLE[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-consistent snapshot and blink.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned TICK_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FRM_W  = $clog2(BLINK_FRAMES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES);

  logic [TICK_W-1:0] r_tick;
  digit_idx_t        r_ptr;
  logic [VAL_W-1:0]  r_value;
  logic [FRM_W-1:0]  r_frame_cnt;
  logic              r_blink_phase;
  logic [AN_W-1:0]   r_an;
  logic [SEG_W-1:0]  r_seg;
  logic              r_frame_tick;

  logic              w_adv;
  logic              w_wrap;
  logic [TICK_W-1:0] w_tick_nxt;
  digit_idx_t        w_ptr_nxt;
  logic [VAL_W-1:0]  w_frame_val;
  logic [NIB_W-1:0]  w_nib;
  logic [FRM_W-1:0]  w_frame_cnt_nxt;
  logic              w_phase_nxt;
  logic              w_lzb;
  logic              w_on;
  logic [AN_W-1:0]   w_an_nxt;
  logic [SEG_W-1:0]  w_seg_dec;

  seg7_hex_decode u_dec (
    .i_nib   (w_nib),
    .o_seg_c (w_seg_dec)
  );

`ifdef SEG7_LZB_EN
  assign w_lzb = lz_blank(w_frame_val, w_ptr_nxt);
`else
  assign w_lzb = 1'b0;
`endif

  // Next-state: outputs are computed for the slot that begins after this edge.
  always_comb begin
    w_adv           = (r_tick == TICK_LAST);
    w_wrap          = w_adv && (r_ptr == 2'd3);
    w_tick_nxt      = w_adv ? '0 : TICK_W'(r_tick + 1'b1);
    w_ptr_nxt       = w_adv ? digit_idx_t'(r_ptr + 2'd1) : r_ptr;
    w_frame_val     = w_wrap ? bus.value : r_value;
    w_nib           = w_frame_val[{w_ptr_nxt, 2'b00} +: NIB_W];
    w_frame_cnt_nxt = r_frame_cnt;
    w_phase_nxt     = r_blink_phase;
    if (!bus.blink) begin
      w_frame_cnt_nxt = '0;
      w_phase_nxt     = 1'b0;
    end else if (w_wrap) begin
      // Counter starts at 1 on the first wrap so the first on-phase spans BLINK_FRAMES full frames.
      if (r_frame_cnt == FRM_LAST) begin
        w_frame_cnt_nxt = FRM_W'(1);
        w_phase_nxt     = ~r_blink_phase;
      end else begin
        w_frame_cnt_nxt = FRM_W'(r_frame_cnt + 1'b1);
      end
    end
    w_on     = bus.dig_en[w_ptr_nxt] && !w_phase_nxt && !w_lzb;
    w_an_nxt = w_on ? ~(AN_W'(4'b0001 << w_ptr_nxt)) : AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick        <= '0;
      r_ptr         <= 2'd0;
      r_value       <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_an          <= 4'b1110;
      r_seg         <= SEG_TABLE[0];
      r_frame_tick  <= 1'b0;
    end else begin
      r_tick        <= w_tick_nxt;
      r_ptr         <= w_ptr_nxt;
      r_value       <= w_frame_val;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_blink_phase <= w_phase_nxt;
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_dec;
      r_frame_tick  <= w_wrap;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_tick = r_frame_tick;

endmodule
